// File: rtl/ccff_chain_loader.sv
// Serializes host bitstream words MSB-first onto one tile's configuration chain.
// Define CCFF_READBACK_EN to enable readback-compare (verify) passes against ccff_tail.
module ccff_chain_loader #(
   parameter int CHAIN_LEN = 20,
   parameter int WORD_W    = 8,
   parameter int CNT_W     = 16
) (
   input  logic              prog_clk,
   input  logic              pReset,
   input  logic              start,
   input  logic              verify_mode,
   input  logic [WORD_W-1:0] bs_data,
   input  logic              bs_valid,
   output logic              bs_ready,
   output logic              ccff_head,
   output logic              ccff_en,
   input  logic              ccff_tail,
   output logic              busy,
   output logic              done,
   output logic              verify_err,
   output logic [CNT_W-1:0]  bit_cnt
);

   localparam int WCW = $clog2(WORD_W);

   typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

   state_t            state_q;
   logic [WORD_W-1:0] shiftReg_q;
   logic [WCW-1:0]    wordCnt_q;
   logic [CNT_W-1:0]  bitCnt_q;
   logic              bsReady_q;
   logic              ccffEn_q;
   logic              busy_q;
   logic              done_q;
   logic              verifyErr_q;
   logic              lastBit_d;
   logic              wordEnd_d;
   logic              mismatch_d;

   assign lastBit_d = (bitCnt_q == CNT_W'(CHAIN_LEN - 1));
   assign wordEnd_d = (wordCnt_q == WCW'(WORD_W - 1));

`ifdef CCFF_READBACK_EN
   logic verify_q;

   // The tail emits bit k of the previous pass while bit k is shifted in now.
   assign mismatch_d = verify_q && (ccff_tail != shiftReg_q[WORD_W-1]);
`else
   logic unusedInputs;

   assign unusedInputs = ccff_tail ^ verify_mode;
   assign mismatch_d   = 1'b0;
`endif

   always_ff @(posedge prog_clk) begin
      if (pReset) begin
         state_q     <= IDLE;
         shiftReg_q  <= '0;
         wordCnt_q   <= '0;
         bitCnt_q    <= '0;
         bsReady_q   <= 1'b0;
         ccffEn_q    <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         verifyErr_q <= 1'b0;
`ifdef CCFF_READBACK_EN
         verify_q    <= 1'b0;
`endif
      end else begin
         case (state_q)
            IDLE, DONE: begin
               if (start) begin
                  state_q     <= LOAD;
                  shiftReg_q  <= '0;
                  bitCnt_q    <= '0;
                  bsReady_q   <= 1'b1;
                  busy_q      <= 1'b1;
                  done_q      <= 1'b0;
                  verifyErr_q <= 1'b0;
`ifdef CCFF_READBACK_EN
                  verify_q    <= verify_mode;
`endif
               end
            end
            LOAD: begin
               if (bs_valid && bsReady_q) begin
                  state_q    <= SHIFT;
                  shiftReg_q <= bs_data;
                  wordCnt_q  <= '0;
                  bsReady_q  <= 1'b0;
                  ccffEn_q   <= 1'b1;
               end
            end
            SHIFT: begin
               shiftReg_q  <= {shiftReg_q[WORD_W-2:0], 1'b0};
               bitCnt_q    <= bitCnt_q + 1'b1;
               wordCnt_q   <= wordCnt_q + 1'b1;
               verifyErr_q <= verifyErr_q | mismatch_d;
               // The chain-length limit takes priority so surplus word bits are dropped.
               if (lastBit_d) begin
                  state_q    <= DONE;
                  shiftReg_q <= '0;
                  ccffEn_q   <= 1'b0;
                  busy_q     <= 1'b0;
                  done_q     <= 1'b1;
               end else if (wordEnd_d) begin
                  state_q   <= LOAD;
                  ccffEn_q  <= 1'b0;
                  bsReady_q <= 1'b1;
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign bs_ready   = bsReady_q;
   assign ccff_head  = shiftReg_q[WORD_W-1];
   assign ccff_en    = ccffEn_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign verify_err = verifyErr_q;
   assign bit_cnt    = bitCnt_q;

endmodule

// File: doc/ccff_chain_loader.md
Name: ccff_chain_loader

Overview:
- Programming-side controller that configures logic-tile configuration chains (ccff_head -> ... -> ccff_tail).
- Accepts bitstream bytes from the host over a valid/ready handshake and serializes them MSB-first onto ccff_head.
- Asserts a per-bit shift enable and counts exactly CHAIN_LEN bits per pass; discards surplus bits in the final byte.
- Sits between the bitstream source and the ccff_head/ccff_tail of one tile chain. Runs entirely in the programming clock domain.

Parameters:
- CHAIN_LEN, 20: number of configuration bits in the attached chain; must be >= 1.
- WORD_W, 8: bitstream word width in bits; must be >= 2.
- CNT_W, 16: width of bit_cnt; must satisfy 2^CNT_W > CHAIN_LEN.

Ports:
- prog_clk  input  1  programming clock; all logic is on the rising edge.
- pReset  input  1  synchronous, active-high reset.
- start  input  1  begin a pass; sampled only in IDLE or DONE.
- verify_mode  input  1  sampled with start; 1 = readback-compare pass.
- bs_data  input  WORD_W  bitstream word, MSB shifted first.
- bs_valid  input  1  bs_data valid.
- bs_ready  output  1  loader accepts a word this cycle.
- ccff_head  output  1  serial bit into the chain.
- ccff_en  output  1  chain captures ccff_head on this prog_clk edge.
- ccff_tail  input  1  serial bit out of the chain.
- busy  output  1  pass in progress (LOAD or SHIFT).
- done  output  1  pass complete; held until the next accepted start.
- verify_err  output  1  sticky readback mismatch flag.
- bit_cnt  output  CNT_W  bits shifted in the current pass.

Behaviour:
- Reset (sync, active-high)
  - State -> IDLE; bs_ready=0, ccff_en=0, ccff_head=0, busy=0, done=0, verify_err=0, bit_cnt=0.
  - Reset mid-pass aborts immediately. Chain contents are then undefined and the host must rerun the pass.
- State IDLE / DONE
  - start=1: go to LOAD; clear bit_cnt, done and verify_err; latch verify_mode.
  - start while busy is ignored.
- State LOAD
  - bs_ready=1, ccff_en=0.
  - On bs_valid && bs_ready: latch bs_data into the shift register, set the in-word counter to 0, go to SHIFT.
  - bs_valid while bs_ready=0 is held by the host; no word is dropped.
- State SHIFT
  - bs_ready=0, ccff_en=1, ccff_head = shift register MSB (driven from a register, glitch-free).
  - Each cycle: shift left by 1, bit_cnt += 1, in-word counter += 1.
  - If bit_cnt+1 == CHAIN_LEN: go to DONE. Remaining bits of the word are discarded.
  - Else if the in-word counter reaches WORD_W-1: go to LOAD.
- Words per pass: ceil(CHAIN_LEN/WORD_W).
- Throughput: at most WORD_W+1 cycles per full word (1 LOAD cycle + WORD_W SHIFT cycles).
- State DONE: done=1, busy=0, ccff_en=0. bit_cnt holds CHAIN_LEN.
- Boundary cases
  - CHAIN_LEN an exact multiple of WORD_W: no discarded bits.
  - CHAIN_LEN=1: one SHIFT cycle, then DONE.
  - start and pReset in the same cycle: reset wins.
  - bit_cnt never wraps, because 2^CNT_W > CHAIN_LEN is required.

Optional Feature:
- Macro: CCFF_READBACK_EN.
- When defined, a pass with latched verify_mode=1 does the following:
  - The host resends the same bitstream.
  - In every SHIFT cycle, ccff_tail is compared with ccff_head. Bit k exiting the tail equals bit k of the previous pass, and bit k is being shifted in now.
  - Any mismatch sets verify_err, which stays set until the next accepted start or reset.
  - The chain is left holding the same contents as before the pass.
- When not defined: verify_mode is ignored, ccff_tail is unused, verify_err is tied to 0, and every pass is a plain load.

Test Plan:
- CHAIN_LEN=20, words 0xA5, 0x3C, 0xF0 -> ccff_head sequence 10100101 00111100 1111; lower nibble of 0xF0 discarded; done after exactly 20 ccff_en cycles; bit_cnt=20; 3 handshakes.
- bs_valid held low for 5 cycles in LOAD after the first word -> bs_ready stays 1, ccff_en=0, bit_cnt frozen at 8; shifting resumes on the next valid.
- pReset asserted when bit_cnt=11 -> next cycle all outputs at reset values, state IDLE; a subsequent start reloads from bit 0.
- start pulsed mid-SHIFT -> ignored, no change to bit_cnt or state; start in DONE -> done clears and a new pass begins.
- CCFF_READBACK_EN defined: chain loaded with 0xA5, 0x3C, 0xF0, then verify pass with the same data -> verify_err=0. Repeat the verify pass with the second word changed to 0x3D -> verify_err=1 at bit 15, held through DONE.
- CHAIN_LEN=16 (exact multiple): 2 words, no discard, done after 16 shift cycles and 2 LOAD cycles.
